// File: rtl/risc16_pkg.sv
// Shared types and constants for the risc16 fetch path: word width, PC step,
// fetch-state encoding and the prefetch-queue entry layout.
package risc16_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] PC_STEP = 16'd2;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } ifq_entry_t;

  localparam int ENTRY_W = $bits(ifq_entry_t);

  // Instructions are halfword aligned; the low address bit is never meaningful.
  function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] pc);
    return pc & 16'hFFFE;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch queue for the fetch unit: DEPTH entries (power of two), flush has
// priority over push/pop, head entry presented combinationally on rdata.
module ifu_fifo
  import risc16_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [ENTRY_W-1:0]       wdata,
  output logic [ENTRY_W-1:0]       rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding imem request feeding a prefetch queue,
// with redirect/flush. Optional stall counter under IFU_STALL_CNT_EN.
module instr_fetch_unit
  import risc16_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          redirect_valid,
  input  logic [15:0]                   redirect_pc,
  output logic                          imem_req,
  output logic [15:0]                   imem_addr,
  input  logic                          imem_ack,
  input  logic [15:0]                   imem_rdata,
  output logic                          instr_valid,
  output logic [15:0]                   instr,
  output logic [15:0]                   instr_pc,
  input  logic                          instr_ready,
`ifdef IFU_STALL_CNT_EN
  output logic [15:0]                   stall_cnt,
`endif
  output logic [1:0]                    dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_count
);

  localparam logic [1:0] S_IDLE = FS_IDLE;
  localparam logic [1:0] S_WAIT = FS_WAIT;
  localparam logic [1:0] S_DROP = FS_DROP;

  // Handshakes: imem_req stays high with imem_addr fixed until the cycle imem_ack
  // is seen (ack may coincide with the issuing cycle); the queue head moves on
  // a cycle where instr_valid & instr_ready are both high.
  logic [1:0]          state_q, state_d;
  logic [15:0]         fetch_pc_q, fetch_pc_d;
  logic [15:0]         req_addr_q, req_addr_d;
  logic                push_w, pop_w;
  logic                fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]  fifo_wdata, fifo_rdata;
  ifq_entry_t          head;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    imem_req   = 1'b0;
    imem_addr  = fetch_pc_q;
    push_w     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!redirect_valid && !fifo_full) begin
          imem_req   = 1'b1;
          req_addr_d = fetch_pc_q;
          if (imem_ack) begin
            push_w     = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_STEP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        imem_req  = 1'b1;
        imem_addr = req_addr_q;
        if (imem_ack) begin
          state_d = S_IDLE;
          if (!redirect_valid) begin
            push_w     = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_STEP;
          end
        end else if (redirect_valid) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        imem_req  = 1'b1;
        imem_addr = req_addr_q;
        if (imem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid) fetch_pc_d = align_pc(redirect_pc);
    // A request in flight at reset is abandoned; nothing is driven or accepted.
    if (rst) begin
      imem_req = 1'b0;
      push_w   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= align_pc(RESET_PC);
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  assign fifo_wdata = {fetch_pc_q, imem_rdata};
  assign pop_w      = instr_valid & instr_ready & ~redirect_valid;

  ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_w),
    .pop   (pop_w),
    .flush (redirect_valid),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (dbg_count)
  );

  assign head        = ifq_entry_t'(fifo_rdata);
  assign instr_valid = ~fifo_empty;
  assign instr       = fifo_empty ? 16'h0000 : head.instr;
  assign instr_pc    = fifo_empty ? 16'h0000 : head.pc;
  assign dbg_state   = state_q;

`ifdef IFU_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (!instr_valid && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-programmable imem responder
// (data = address ^ 16'hC3C3). Define IFU_STALL_CNT_EN to include the stall counter.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_count;
`ifdef IFU_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] lat;
  logic [7:0] wait_cnt;

  instr_fetch_unit #(.RESET_PC(16'h0000), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
`ifdef IFU_STALL_CNT_EN
    .stall_cnt      (stall_cnt),
`endif
    .dbg_state      (dbg_state),
    .dbg_count      (dbg_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // imem responder: acks after 'lat' waiting cycles, 0 means same cycle
  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wait_cnt <= 8'd0;
    else wait_cnt <= wait_cnt + 8'd1;
  end
  assign imem_ack   = imem_req && (wait_cnt == lat);
  assign imem_rdata = imem_addr ^ 16'hC3C3;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    instr_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    lat = 8'd0;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    instr_ready = 1'b0;
    repeat (2) step();
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got=%h exp=0000", instr); end
    checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got=%h exp=0000", instr_pc); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    checks++; if (dbg_count !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", dbg_count); end
  endtask

  task automatic test_zero_latency();
    lat = 8'd0;
    do_reset();
    instr_ready = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL zl_c1_req got=%b/%h exp=1/0000", imem_req, imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL zl_c1_valid got=%b exp=0", instr_valid); end
    step(); #1;
    checks++; if (imem_addr !== 16'h0002 || imem_req !== 1'b1) begin errors++; $display("FAIL zl_c2_addr got=%b/%h exp=1/0002", imem_req, imem_addr); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr !== 16'hC3C3) begin errors++; $display("FAIL zl_c2_head got=%b/%h/%h exp=1/0000/c3c3", instr_valid, instr_pc, instr); end
    step(); #1;
    checks++; if (imem_addr !== 16'h0004 || imem_req !== 1'b1) begin errors++; $display("FAIL zl_c3_addr got=%b/%h exp=1/0004", imem_req, imem_addr); end
    checks++; if (instr_pc !== 16'h0002 || instr !== 16'hC3C1) begin errors++; $display("FAIL zl_c3_head got=%h/%h exp=0002/c3c1", instr_pc, instr); end
  endtask

  task automatic test_backpressure();
    int n_req;
    lat = 8'd3;
    do_reset();
    n_req = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (imem_req && imem_ack) n_req++;
      if (instr_valid) begin
        checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL bp_hold_pc cyc=%0d got=%h exp=0000", i, instr_pc); end
      end
      step();
    end
    #1;
    checks++; if (n_req != 2) begin errors++; $display("FAIL bp_req_count got=%0d exp=2", n_req); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_low got=%b exp=0", imem_req); end
    checks++; if (dbg_count !== 2'd2 || instr_valid !== 1'b1) begin errors++; $display("FAIL bp_full got=%0d/%b exp=2/1", dbg_count, instr_valid); end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0004) begin errors++; $display("FAIL bp_after_pop got=%b/%h exp=1/0004", imem_req, imem_addr); end
    checks++; if (instr_pc !== 16'h0002 || instr !== 16'hC3C1) begin errors++; $display("FAIL bp_head2 got=%h/%h exp=0002/c3c1", instr_pc, instr); end
  endtask

  task automatic test_redirect();
    logic got;
    lat = 8'd3;
    do_reset();
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL rd_issue got=%b/%h exp=1/0000", imem_req, imem_addr); end
    step();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0041;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL rd_hold got=%b/%h exp=1/0000", imem_req, imem_addr); end
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (dbg_state !== 2'd2 || imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL rd_drop got=%0d/%b/%h exp=2/1/0000", dbg_state, imem_req, imem_addr); end
    step(); #1;
    checks++; if (instr_valid !== 1'b0 || dbg_count !== 2'd0) begin errors++; $display("FAIL rd_empty_ack got=%b/%0d exp=0/0", instr_valid, dbg_count); end
    step(); #1;
    checks++; if (dbg_state !== 2'd0 || imem_req !== 1'b1 || imem_addr !== 16'h0040) begin errors++; $display("FAIL rd_new_fetch got=%0d/%b/%h exp=0/1/0040", dbg_state, imem_req, imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rd_empty_new got=%b exp=0", instr_valid); end
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(); #1;
      if (instr_valid) begin got = 1'b1; break; end
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL rd_timeout got=%b exp=1", got); end
    checks++; if (instr_pc !== 16'h0040 || instr !== 16'hC383) begin errors++; $display("FAIL rd_head got=%h/%h exp=0040/c383", instr_pc, instr); end
  endtask

  task automatic test_wrap();
    lat = 8'd0;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wr_blocked got=%b exp=0", imem_req); end
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'hFFFE) begin errors++; $display("FAIL wr_issue got=%b/%h exp=1/fffe", imem_req, imem_addr); end
    step(); #1;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'hFFFE || instr !== 16'h3C3D) begin errors++; $display("FAIL wr_head got=%b/%h/%h exp=1/fffe/3c3d", instr_valid, instr_pc, instr); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL wr_next got=%h exp=0000", imem_addr); end
  endtask

  task automatic test_full_redirect();
    lat = 8'd0;
    do_reset();
    step();
    step(); #1;
    checks++; if (imem_req !== 1'b0 || dbg_count !== 2'd2 || instr_pc !== 16'h0000) begin errors++; $display("FAIL fr_full got=%b/%0d/%h exp=0/2/0000", imem_req, dbg_count, instr_pc); end
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    step();
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0 || dbg_count !== 2'd0) begin errors++; $display("FAIL fr_flushed got=%b/%0d exp=0/0", instr_valid, dbg_count); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin errors++; $display("FAIL fr_target got=%b/%h exp=1/0100", imem_req, imem_addr); end
    step(); #1;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0100 || dbg_count !== 2'd1) begin errors++; $display("FAIL fr_head got=%b/%h/%0d exp=1/0100/1", instr_valid, instr_pc, dbg_count); end
  endtask

  task automatic test_reset_mid_request();
    logic got;
    lat = 8'd3;
    do_reset();
    step();
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mr_req_in_rst got=%b exp=0", imem_req); end
    repeat (2) step();
    rst = 1'b0;
    #1;
    checks++; if (dbg_state !== 2'd0 || imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL mr_restart got=%0d/%b/%h exp=0/1/0000", dbg_state, imem_req, imem_addr); end
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(); #1;
      if (instr_valid) begin got = 1'b1; break; end
    end
    checks++; if (got !== 1'b1 || instr_pc !== 16'h0000) begin errors++; $display("FAIL mr_first got=%b/%h exp=1/0000", got, instr_pc); end
  endtask

`ifdef IFU_STALL_CNT_EN
  task automatic test_stall_cnt();
    lat = 8'd0;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0000;
    repeat (10) step();
    #1;
    checks++; if (stall_cnt !== 16'd10) begin errors++; $display("FAIL sc_ten got=%0d exp=10", stall_cnt); end
    repeat (70000) step();
    #1;
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sc_sat got=%h exp=ffff", stall_cnt); end
    redirect_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_zero_latency();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_full_redirect();
    test_reset_mid_request();
`ifdef IFU_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: first fetch address after reset; bit 0 SHALL be ignored (treated as 0).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: prefetch queue entries; legal values are 2 or 4.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 redirect_valid  input  1  taken branch/jump; flush the queue and refetch from redirect_pc.
REQ-006 redirect_pc  input  16  new fetch address; bit 0 forced to 0.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  16  request address; held stable while imem_req=1.
REQ-009 imem_ack  input  1  one-cycle pulse; imem_rdata valid; may arrive in the same cycle as imem_req.
REQ-010 imem_rdata  input  16  fetched instruction word.
REQ-011 instr_valid  output  1  queue head valid to the datapath.
REQ-012 instr  output  16  queue head instruction; opcode in [15:12].
REQ-013 instr_pc  output  16  address of the head instruction.
REQ-014 instr_ready  input  1  datapath accepts the head; pop when instr_valid & instr_ready.
REQ-015 stall_cnt  output  16  present only under IFU_STALL_CNT_EN.

Function
REQ-016 States SHALL be IDLE (no outstanding request), WAIT (request outstanding, data kept) and DROP (request outstanding, data to be discarded).
REQ-017 IDLE->WAIT SHALL occur when occupancy < FIFO_DEPTH and redirect_valid=0; imem_req=1 and imem_addr=fetch_pc in that cycle.
REQ-018 At most one request SHALL be outstanding; imem_req SHALL stay high with a constant address until imem_ack.
REQ-019 On imem_ack in WAIT: push {fetch_pc, imem_rdata}; fetch_pc += 2 modulo 2^16 (16'hFFFE -> 16'h0000); go to IDLE.
REQ-020 An ack-in-the-same-cycle request SHALL behave as issue plus ack in one cycle; the entry is visible on instr_valid the next cycle.
REQ-021 A request SHALL only be issued if occupancy + outstanding < FIFO_DEPTH, so the queue never overflows; a simultaneous push and pop SHALL leave occupancy unchanged.
REQ-022 On redirect_valid: flush the queue (instr_valid=0 next cycle) and set fetch_pc=redirect_pc&16'hFFFE; WAIT->DROP, IDLE stays IDLE, DROP stays DROP with the target updated.
REQ-023 Redirect SHALL take priority over a same-cycle push and pop; a same-cycle ack SHALL be discarded.
REQ-024 In DROP, imem_ack SHALL discard the data and return to IDLE; the new fetch issues the following cycle.
REQ-025 Queue order SHALL be FIFO; instr and instr_pc SHALL be stable while instr_valid=1 and instr_ready=0.

Reset
REQ-026 On rst: state IDLE, queue empty, fetch_pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, stall_cnt=0.
REQ-027 Reset mid-request SHALL abandon the request; the imem responder shares rst and SHALL NOT ack after reset.
REQ-028 The first request SHALL issue in the first cycle with rst=0.

Configuration
REQ-029 With IFU_STALL_CNT_EN defined: stall_cnt increments each cycle with rst=0 and instr_valid=0, and saturates at 16'hFFFF.
REQ-030 Without IFU_STALL_CNT_EN: the port and counter SHALL be absent, with all other behaviour identical.

Structure
REQ-031 Package risc16_pkg SHALL hold WORD_W=16, PC_STEP=2, the fetch-state enum and the queue-entry typedef {pc, instr}.
REQ-032 The queue SHALL be a sub-module ifu_fifo (parameter DEPTH; push, pop, flush, full, empty, count).

Verification
REQ-033 Reset, zero-latency ack, instr_ready=1 -> imem_addr 0,2,4 on consecutive cycles; instr_valid from cycle 2.
REQ-034 3-cycle ack latency, instr_ready=0, FIFO_DEPTH=2 -> exactly 2 requests; imem_req stays low until a pop.
REQ-035 Redirect to 16'h0041 while WAIT -> ack data dropped; next imem_addr=16'h0040; queue empty meanwhile.
REQ-036 fetch_pc=16'hFFFE, ack -> instr_pc=16'hFFFE; next imem_addr=16'h0000.
REQ-037 Full queue, same-cycle pop and redirect -> queue empty; no overflow; new fetch from the redirect target.
REQ-038 IFU_STALL_CNT_EN, 10 stall cycles after reset -> stall_cnt=10; forced 70000 stall cycles -> 16'hFFFF.
